// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: N masters share one slave, grant held per cyc burst.
// Optional slave watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [N_MASTERS-1:0]            m_cyc,
    input  logic [N_MASTERS-1:0]            m_stb,
    input  logic [N_MASTERS-1:0]            m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_adr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_dat_w,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_sel,
    output logic [DATA_W-1:0]               m_dat_r,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [N_MASTERS-1:0]            m_err,
    output logic                            s_cyc,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [ADDR_W-1:0]               s_adr,
    output logic [DATA_W-1:0]               s_dat_w,
    output logic [DATA_W/8-1:0]             s_sel,
    input  logic [DATA_W-1:0]               s_dat_r,
    input  logic                            s_ack,
    input  logic                            s_err,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            busy
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (N_MASTERS > 2) ? 2 : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]           state_reg, state_next;
    logic [N_MASTERS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]     last_reg, last_next;

    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic                 win_found;
    logic [N_MASTERS-1:0] win_onehot;

    logic                 owner_cyc;
    logic                 owner_stb;
    logic                 owner_we;
    logic                 timeout_hit;

    // Scan starting just after the previous winner so every requester gets a turn.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand_idx = IDX_W'((int'(last_reg) + k) % N_MASTERS);
            if (!win_found && m_cyc[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    assign win_onehot = N_MASTERS'(1) << win_idx;

    assign owner_cyc = |(m_cyc & grant_reg);
    assign owner_stb = |(m_stb & grant_reg);
    assign owner_we  = |(m_we  & grant_reg);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = ST_BUSY;
                    grant_next = win_onehot;
                    last_next  = win_idx;
                end
            end
            default: begin
                // Release only once the owner drops cyc; hand straight over if anyone waits.
                if (!owner_cyc) begin
                    if (win_found) begin
                        grant_next = win_onehot;
                        last_next  = win_idx;
                    end else begin
                        state_next = ST_IDLE;
                        grant_next = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            last_reg  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_reg;

    assign timeout_hit = (state_reg == ST_BUSY) && (wd_cnt_reg == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_cnt_reg <= '0;
        end else if (timeout_hit || s_ack || s_err || (state_reg != ST_BUSY) ||
                     (grant_next != grant_reg)) begin
            wd_cnt_reg <= '0;
        end else if (owner_stb) begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    // Grant is zero when idle, so the AND-OR mux also blanks the slave side.
    logic [ADDR_W-1:0] adr_masked [N_MASTERS];
    logic [DATA_W-1:0] dat_masked [N_MASTERS];
    logic [SEL_W-1:0]  sel_masked [N_MASTERS];

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_mask
            assign adr_masked[gi] = grant_reg[gi] ? m_adr[gi*ADDR_W +: ADDR_W]  : '0;
            assign dat_masked[gi] = grant_reg[gi] ? m_dat_w[gi*DATA_W +: DATA_W] : '0;
            assign sel_masked[gi] = grant_reg[gi] ? m_sel[gi*SEL_W +: SEL_W]    : '0;
            assign m_ack[gi]      = grant_reg[gi] & s_ack;
            assign m_err[gi]      = grant_reg[gi] & (s_err | timeout_hit);
        end
    endgenerate

    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            s_adr   = s_adr   | adr_masked[i];
            s_dat_w = s_dat_w | dat_masked[i];
            s_sel   = s_sel   | sel_masked[i];
        end
    end

    assign s_cyc   = owner_cyc & ~timeout_hit;
    assign s_stb   = owner_stb & ~timeout_hit;
    assign s_we    = owner_we;
    assign m_dat_r = s_dat_r;
    assign grant   = grant_reg;
    assign busy    = (state_reg == ST_BUSY);

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B4 (classic) arbiter that shares the single management-SoC slave port between `N_MASTERS` bus masters. Grant is registered, ownership is held for the whole `cyc` burst of the winning master, and slave responses are steered back to the owner only. It sits between the masters (CPU, DMA, debug bridge) and the existing single-cycle-ack slave FSM.

## Interface
- `N_MASTERS`, 2: number of requesters, legal 2..4.
- `ADDR_W`, 30: word address width.
- `DATA_W`, 32: data width, multiple of 8.
- `TIMEOUT_CYCLES`, 255: watchdog limit, only used when the timeout feature is compiled in. Legal range is 1..65535.

- `sys_clk`  in  1  single clock, all state on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `m_cyc`  in  N_MASTERS  per-master cycle request.
- `m_stb`  in  N_MASTERS  per-master strobe.
- `m_we`  in  N_MASTERS  per-master write enable.
- `m_adr`  in  N_MASTERS*ADDR_W  packed addresses, master i at bits [i*ADDR_W +: ADDR_W].
- `m_dat_w`  in  N_MASTERS*DATA_W  packed write data.
- `m_sel`  in  N_MASTERS*DATA_W/8  packed byte selects.
- `m_dat_r`  out  DATA_W  read data, broadcast to all masters.
- `m_ack`  out  N_MASTERS  per-master ack.
- `m_err`  out  N_MASTERS  per-master error.
- `s_cyc`, `s_stb`, `s_we`  out  1  slave controls.
- `s_adr`  out  ADDR_W  slave address.
- `s_dat_w`  out  DATA_W  slave write data.
- `s_sel`  out  DATA_W/8  slave byte selects.
- `s_dat_r`  in  DATA_W  slave read data.
- `s_ack`, `s_err`  in  1  slave responses.
- `grant`  out  N_MASTERS  one-hot owner; 0 when idle.
- `busy`  out  1  high in BUSY state.

## Operation
- Two states: IDLE and BUSY. The register set is the state, `grant` (one-hot), and `last` (index of the previous winner).
- Reset values: state = IDLE, `grant` = 0, `last` = N_MASTERS-1, so master 0 wins first.
- Every output is 0 while in reset and while IDLE: `s_*` controls, `m_ack`, `m_err`, `busy`. `m_dat_r` follows `s_dat_r` at all times.
- **Winner selection:** the first asserted `m_cyc[i]` scanning i = last+1, last+2, … modulo N_MASTERS. Only `m_cyc` counts as a request; `m_stb` is ignored for arbitration.
- **IDLE → BUSY:** when any `m_cyc` is high. `grant` is set to the winner and `last` is set to the winner index.
- **BUSY:**
  - The owner's `cyc`/`stb`/`we`/`adr`/`dat_w`/`sel` drive `s_*` combinationally.
  - `m_ack[owner]` = `s_ack`, `m_err[owner]` = `s_err`.
  - Non-owners see `ack` = `err` = 0 and are stalled.
- **BUSY, owner `m_cyc` low at the clock edge:** if any other `m_cyc` is high, re-arbitrate in that same edge and stay BUSY with the new `grant`. Otherwise go to IDLE and clear `grant`.
- **Owner lock:** a master holding `cyc` keeps the bus indefinitely; there is no pre-emption. Back-to-back `stb` cycles within one `cyc` stay with the same owner.
- **Owner drops `cyc` in the same cycle the slave asserts `s_ack`:** the ack is still delivered (combinational pass-through), then release happens at the edge.
- **Reset mid-transaction:** `grant` clears immediately (asynchronous), so `s_cyc` drops in the same cycle. No ack is delivered.

## Timing
- Grant latency: 1 cycle from `m_cyc` rising in IDLE to `s_cyc` rising.
- Handover latency: the new owner drives the slave in the cycle after the old owner's `cyc` falls. There is no idle gap cycle.
- Response path: zero-latency combinational for `ack`, `err` and `dat_r`.
- With the existing single-cycle-ack slave, one access takes 2 cycles after grant (`stb` cycle, ack cycle).

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles in BUSY where `s_stb` = 1 and `s_ack` = `s_err` = 0.
  - When the count reaches `TIMEOUT_CYCLES`, for exactly one cycle: `m_err[owner]` = 1 and `s_cyc` / `s_stb` are forced to 0.
  - The counter then clears, and the owner keeps the grant.
  - The counter also clears on any `s_ack`/`s_err`, on a change of owner, and on reset.
- `WB_ARB_TIMEOUT_EN` undefined: no counter is built, and a hung slave stalls the owner forever.

## Test plan
- **Single master:** master 0 raises `cyc`/`stb` with `we`=1, `adr`=0x100, `dat_w`=0xDEADBEEF.
  - Expect `grant`=0b01 and the `s_*` signals to mirror those values one cycle later.
  - Expect `m_ack[0]` to pulse with `s_ack`, then IDLE after `cyc` drops.
- **Round-robin:** masters 0 and 1 request continuously, each dropping `cyc` after one ack.
  - Expect grant order 0, 1, 0, 1 with no gap cycle at handover.
  - Expect `m_ack[1]` = 0 whenever master 0 owns the bus.
- **Lock:** master 1 holds `cyc` across 3 `stb`/ack pairs while master 0 is requesting.
  - Expect `grant` to stay 0b10 for all 3 pairs.
  - Expect master 0 to be granted on the cycle after master 1's `cyc` falls.
- **Error pass-through:** slave asserts `s_err` for master 1's read.
  - Expect `m_err[1]` = 1 and `m_err[0]` = 0 in the same cycle.
- **Timeout** (with `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): slave never acks.
  - Expect `m_err[owner]` = 1 for one cycle with `s_cyc` = 0 in that cycle.
  - Expect the same to recur every 9 cycles while the owner keeps `stb` high.
- **Reset mid-operation:** assert `sys_rst` while master 0 is granted and `s_stb` = 1.
  - Expect `s_cyc`, `grant` and `busy` to be 0 in that same cycle.
  - After release, expect master 0 to be the first to win when both masters request.
